pc_sequencer: RTL and testbench

//  Fetch/decode/execute sequencer that owns the 8-bit program counter.
//  - Runs the instruction-fetch handshake with program memory.
//  - Waits for the decoder, then for the ALU to finish multi-cycle operations.
//  - Resolves conditional jumps, CALL and RET using a small hardware return stack.
//  - Sits between program memory, the decoder and the ALU flag register.

---
 rtl/pc_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/execute sequencer owning the program counter,
// with conditional jumps and a small hardware CALL/RET return stack.
module pc_sequencer #(
  parameter int AW          = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          fetch_req,
  output logic [AW-1:0] fetch_addr,
  input  logic          fetch_ack,
  input  logic          dec_valid,
  input  logic          dec_jmp,
  input  logic [2:0]    dec_op,
  input  logic          dec_call,
  input  logic          dec_ret,
  input  logic          dec_halt,
  input  logic [AW-1:0] dec_addr,
  input  logic [7:0]    flag,
  output logic          exec_start,
  input  logic          exec_done,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic          stack_err
);

  localparam int IW  = $clog2(STACK_DEPTH);
  localparam int SPW = IW + 1;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_UPDATE,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    K_PLAIN,
    K_JMP,
    K_CALL,
    K_RET
  } kind_e;

  state_e           state_q, state_d;
  kind_e            kind_q, kind_d;
  logic [2:0]       op_q, op_d;
  logic [AW-1:0]    tgt_q, tgt_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             err_q, err_d;
  logic             req_q, req_d;

  logic [AW-1:0]    stack_q [STACK_DEPTH];
  logic             push_en;
  logic [IW-1:0]    push_idx;
  logic [AW-1:0]    push_data;

  logic [AW-1:0]    pc_inc;
  logic [SPW-1:0]   sp_dec;
  logic             sp_full;
  logic             sp_empty;
  logic             f0;
  logic             f2;
  logic             taken;
  logic             unused_flag;

  assign unused_flag = ^{flag[7:3], flag[1]};

  assign pc_inc   = pc_q + AW'(1);
  assign sp_dec   = sp_q - SPW'(1);
  assign sp_full  = (sp_q == SPW'(STACK_DEPTH));
  assign sp_empty = (sp_q == '0);
  assign f0       = flag[0];
  assign f2       = flag[2];

  always_comb begin
    taken = 1'b0;
    unique case (op_q)
      3'b000: taken = 1'b1;
      3'b001: taken = f0 & ~f2;
      3'b010: taken = ~f0;
      3'b011: taken = ~f0 & ~f2;
      3'b100: taken = ~f0 & f2;
      3'b101: taken = f0;
      3'b110: taken = ~f0;
      3'b111: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    op_d       = op_q;
    tgt_d      = tgt_q;
    pc_d       = pc_q;
    sp_d       = sp_q;
    err_d      = err_q;
    exec_start = 1'b0;
    push_en    = 1'b0;
    push_idx   = sp_q[IW-1:0];
    push_data  = pc_inc;

    unique case (state_q)
      S_FETCH: begin
        if (req_q && fetch_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (dec_valid) begin
          op_d  = dec_op;
          tgt_d = dec_addr;
          priority case (1'b1)
            dec_halt: state_d = S_HALT;
            dec_ret: begin
              kind_d  = K_RET;
              state_d = S_UPDATE;
            end
            dec_call: begin
              kind_d  = K_CALL;
              state_d = S_UPDATE;
            end
            dec_jmp: begin
              kind_d  = K_JMP;
              state_d = S_UPDATE;
            end
            default: begin
              kind_d     = K_PLAIN;
              state_d    = S_EXEC;
              exec_start = 1'b1;
            end
          endcase
        end
      end
      S_EXEC: begin
        if (exec_done) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        state_d = S_FETCH;
        unique case (kind_q)
          K_PLAIN: pc_d = pc_inc;
          K_JMP:   pc_d = taken ? tgt_q : pc_inc;
          K_CALL: begin
            pc_d = tgt_q;
            if (sp_full) begin
              err_d = 1'b1;
            end else begin
              push_en = 1'b1;
              sp_d    = sp_q + SPW'(1);
            end
          end
          K_RET: begin
            if (sp_empty) begin
              err_d = 1'b1;
              pc_d  = pc_inc;
            end else begin
              pc_d = stack_q[sp_dec[IW-1:0]];
              sp_d = sp_dec;
            end
          end
          default: pc_d = pc_inc;
        endcase
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Request is registered so it is low in reset and the first cycle after.
  assign req_d = (state_d == S_FETCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      kind_q  <= K_PLAIN;
      op_q    <= 3'b000;
      tgt_q   <= '0;
      pc_q    <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      op_q    <= op_d;
      tgt_q   <= tgt_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      req_q   <= req_d;
    end
  end

  // Return-stack storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[push_idx] <= push_data;
  end

  assign fetch_req  = req_q;
  assign fetch_addr = pc_q;
  assign pc         = pc_q;
  assign halted     = (state_q == S_HALT);
  assign stack_err  = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of fetch handshake, jumps,
// CALL/RET stack behaviour, halt and asynchronous reset.
module tb_pc_sequencer;

  logic       clk;
  logic       rst_n;
  logic       fetch_req;
  logic [7:0] fetch_addr;
  logic       fetch_ack;
  logic       dec_valid;
  logic       dec_jmp;
  logic [2:0] dec_op;
  logic       dec_call;
  logic       dec_ret;
  logic       dec_halt;
  logic [7:0] dec_addr;
  logic [7:0] flag;
  logic       exec_start;
  logic       exec_done;
  logic [7:0] pc;
  logic       halted;
  logic       stack_err;

  int tests;
  int fails;

  localparam int PLAIN = 0;
  localparam int JMP   = 1;
  localparam int CALL  = 2;
  localparam int RET   = 3;
  localparam int HALT  = 4;

  pc_sequencer #(.AW(8), .STACK_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ack  (fetch_ack),
    .dec_valid  (dec_valid),
    .dec_jmp    (dec_jmp),
    .dec_op     (dec_op),
    .dec_call   (dec_call),
    .dec_ret    (dec_ret),
    .dec_halt   (dec_halt),
    .dec_addr   (dec_addr),
    .flag       (flag),
    .exec_start (exec_start),
    .exec_done  (exec_done),
    .pc         (pc),
    .halted     (halted),
    .stack_err  (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (fetch_req !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ":req"}, 32'(fetch_req), 32'd1);
  endtask

  task automatic step(input string tag, input logic [7:0] exp_pc,
                      input int kind, input logic [2:0] op,
                      input logic [7:0] tgt, input logic [7:0] flg);
    wait_req(tag);
    chk({tag, ":addr"}, 32'(fetch_addr), 32'(exp_pc));
    chk({tag, ":pc"}, 32'(pc), 32'(exp_pc));
    fetch_ack = 1'b1;
    @(posedge clk); #1;
    fetch_ack = 1'b0;
    chk({tag, ":req_drop"}, 32'(fetch_req), 32'd0);
    dec_valid = 1'b1;
    dec_jmp   = (kind == JMP);
    dec_call  = (kind == CALL);
    dec_ret   = (kind == RET);
    dec_halt  = (kind == HALT);
    dec_op    = op;
    dec_addr  = tgt;
    flag      = flg;
    #1;
    chk({tag, ":start"}, 32'(exec_start), 32'(kind == PLAIN));
    @(posedge clk); #1;
    dec_valid = 1'b0;
    dec_jmp   = 1'b0;
    dec_call  = 1'b0;
    dec_ret   = 1'b0;
    dec_halt  = 1'b0;
    dec_addr  = 8'h00;
    dec_op    = 3'b000;
    if (kind == PLAIN) begin
      chk({tag, ":start_pulse"}, 32'(exec_start), 32'd0);
      @(posedge clk); #1;
      exec_done = 1'b1;
      @(posedge clk); #1;
      exec_done = 1'b0;
    end
    if (kind == HALT) begin
      for (int i = 0; i < 3; i++) begin
        chk({tag, ":halted"}, 32'(halted), 32'd1);
        chk({tag, ":halt_req"}, 32'(fetch_req), 32'd0);
        chk({tag, ":halt_pc"}, 32'(pc), 32'(exp_pc));
        @(posedge clk); #1;
      end
    end else begin
      @(posedge clk); #1;
      flag = 8'h00;
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    fetch_ack = 1'b0;
    dec_valid = 1'b0;
    dec_jmp   = 1'b0;
    dec_op    = 3'b000;
    dec_call  = 1'b0;
    dec_ret   = 1'b0;
    dec_halt  = 1'b0;
    dec_addr  = 8'h00;
    flag      = 8'h00;
    exec_done = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_req", 32'(fetch_req), 32'd0);
    chk("rst_start", 32'(exec_start), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_err", 32'(stack_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step("seq0", 8'h00, PLAIN, 3'b000, 8'h00, 8'h00);
    step("seq1", 8'h01, PLAIN, 3'b000, 8'h00, 8'h00);
    step("seq2", 8'h02, PLAIN, 3'b000, 8'h00, 8'h00);

    step("jmp10", 8'h03, JMP, 3'b000, 8'h10, 8'h00);
    step("jne_t", 8'h10, JMP, 3'b010, 8'h40, 8'h00);
    step("back10", 8'h40, JMP, 3'b000, 8'h10, 8'h00);
    step("jne_n", 8'h10, JMP, 3'b010, 8'h40, 8'h01);

    step("jb_t", 8'h11, JMP, 3'b100, 8'h50, 8'h04);
    step("jb_n", 8'h50, JMP, 3'b100, 8'h60, 8'h05);
    step("never", 8'h51, JMP, 3'b111, 8'h70, 8'hFF);
    step("je_n", 8'h52, JMP, 3'b001, 8'h70, 8'h05);
    step("jmpff", 8'h53, JMP, 3'b000, 8'hFF, 8'h00);
    step("wrap", 8'hFF, PLAIN, 3'b000, 8'h00, 8'h00);

    step("to20", 8'h00, JMP, 3'b000, 8'h20, 8'h00);
    step("call80", 8'h20, CALL, 3'b000, 8'h80, 8'h00);
    step("ret21", 8'h80, RET, 3'b000, 8'h00, 8'h00);
    chk("ret_err", 32'(stack_err), 32'd0);

    step("c1", 8'h21, CALL, 3'b000, 8'h30, 8'h00);
    step("c2", 8'h30, CALL, 3'b000, 8'h40, 8'h00);
    step("c3", 8'h40, CALL, 3'b000, 8'h50, 8'h00);
    step("c4", 8'h50, CALL, 3'b000, 8'h60, 8'h00);
    chk("c4_err", 32'(stack_err), 32'd0);
    step("c5", 8'h60, CALL, 3'b000, 8'h70, 8'h00);
    chk("ovf_err", 32'(stack_err), 32'd1);
    step("r1", 8'h70, RET, 3'b000, 8'h00, 8'h00);
    step("r2", 8'h51, RET, 3'b000, 8'h00, 8'h00);
    step("r3", 8'h41, RET, 3'b000, 8'h00, 8'h00);
    step("r4", 8'h31, RET, 3'b000, 8'h00, 8'h00);
    step("r5", 8'h22, RET, 3'b000, 8'h00, 8'h00);
    wait_req("unf");
    chk("unf_pc", 32'(pc), 32'h23);
    chk("unf_err", 32'(stack_err), 32'd1);

    step("hlt", 8'h23, HALT, 3'b000, 8'h00, 8'h00);

    rst_n = 1'b0;
    #1;
    chk("r2_pc", 32'(pc), 32'h0);
    chk("r2_halted", 32'(halted), 32'd0);
    chk("r2_err", 32'(stack_err), 32'd0);
    chk("r2_req", 32'(fetch_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step("s0", 8'h00, PLAIN, 3'b000, 8'h00, 8'h00);
    wait_req("stall");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall_req", 32'(fetch_req), 32'd1);
      chk("stall_pc", 32'(pc), 32'h01);
      chk("stall_addr", 32'(fetch_addr), 32'h01);
    end
    rst_n = 1'b0;
    #1;
    chk("r3_pc", 32'(pc), 32'h0);
    chk("r3_req", 32'(fetch_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post", 8'h00, PLAIN, 3'b000, 8'h00, 8'h00);
    wait_req("end");
    chk("end_pc", 32'(pc), 32'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
